reaction_timer_top: RTL and testbench

REACTION_TIMER_TOP -- requirements
Module: reaction_timer_top

---
 rtl/reaction_timer_top.sv | 147 ++++++++++++++
 tb/tb_reaction_timer_top.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_top.sv
// Reaction-time game: random delay, lamps on, measure button latency in ms.
// Also provides a free-running divided clock and the LFSR state for display.
module reaction_timer_top #(
   parameter int CLK_PER_MS = 50000,
   parameter int SLOW_MS    = 1000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic        LCDAck,
   output logic [7:0]  LED,
   output logic [9:0]  ReactionTime,
   output logic        Cheat,
   output logic        Slow,
   output logic        Wait,
   output logic        LCDUpdate,
   output logic [12:0] RandomGen,
   output logic        ClkOut
);

   localparam int CW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_MS - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_MS / 2 - 1);
   localparam logic [9:0]    SLOW_LIM = 10'(SLOW_MS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TIMING, S_DONE} state_t;

   state_t        state, state_next;
   logic          rst_meta, rst_sync_n;
   logic [CW-1:0] div_cnt, pre_cnt;
   logic          start_q, start_edge, ms_tick;
   logic [11:0]   wait_cnt, wait_cnt_next, delay_ms, delay_next;
   logic [9:0]    rt_next;
   logic          cheat_next, slow_next;
   logic [7:0]    led_next;

   // NOTE: reset asserts asynchronously but releases only after two clock edges,
   // so every downstream flop leaves reset on the same clean edge.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rst_meta   <= 1'b0;
         rst_sync_n <= 1'b0;
      end else begin
         rst_meta   <= 1'b1;
         rst_sync_n <= rst_meta;
      end
   end

   assign start_edge = Start & ~start_q;
   assign ms_tick    = (pre_cnt == CNT_LAST);

   always_ff @(posedge Clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         div_cnt   <= '0;
         ClkOut    <= 1'b0;
         RandomGen <= 13'h0001;
         start_q   <= 1'b0;
      end else begin
         div_cnt   <= (div_cnt == CNT_LAST) ? '0 : div_cnt + 1'b1;
         if (div_cnt == CNT_HALF || div_cnt == CNT_LAST)
            ClkOut <= ~ClkOut;
         RandomGen <= {RandomGen[11:0],
                       RandomGen[12] ^ RandomGen[3] ^ RandomGen[2] ^ RandomGen[0]};
         start_q   <= Start;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_next    = state;
      rt_next       = ReactionTime;
      cheat_next    = Cheat;
      slow_next     = Slow;
      wait_cnt_next = wait_cnt;
      delay_next    = delay_ms;
      unique case (state)
         S_IDLE: if (start_edge) begin
            rt_next       = '0;
            cheat_next    = 1'b0;
            slow_next     = 1'b0;
            delay_next    = 12'd1000 + {1'b0, RandomGen[10:0]};
            wait_cnt_next = '0;
            state_next    = S_WAIT;
         end
         S_WAIT: if (start_edge) begin
            cheat_next = 1'b1;
            rt_next    = '0;
            state_next = S_DONE;
         end else if (ms_tick) begin
            if (wait_cnt + 12'd1 == delay_ms) state_next    = S_TIMING;
            else                              wait_cnt_next = wait_cnt + 12'd1;
         end
         // Timeout beats a press that lands on the same tick.
         S_TIMING: if (ms_tick && (ReactionTime + 10'd1 == SLOW_LIM)) begin
            rt_next    = SLOW_LIM;
            slow_next  = 1'b1;
            state_next = S_DONE;
         end else if (start_edge) begin
            state_next = S_DONE;
         end else if (ms_tick) begin
            rt_next = ReactionTime + 10'd1;
         end
         S_DONE:  if (LCDAck) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      led_next = 8'h00;
      case (state_next)
         S_IDLE:   led_next = 8'h01;
         S_TIMING: led_next = 8'hFF;
         default:  led_next = 8'h00;
      endcase
   end

   // Outputs are registered from the next state so they change with the state.
   always_ff @(posedge Clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state        <= S_IDLE;
         pre_cnt      <= '0;
         wait_cnt     <= '0;
         delay_ms     <= '0;
         ReactionTime <= '0;
         Cheat        <= 1'b0;
         Slow         <= 1'b0;
         LED          <= 8'h01;
         Wait         <= 1'b0;
         LCDUpdate    <= 1'b0;
      end else begin
         state        <= state_next;
         if (state_next != state && (state_next == S_WAIT || state_next == S_TIMING))
            pre_cnt <= '0;
         else
            pre_cnt <= ms_tick ? '0 : pre_cnt + 1'b1;
         wait_cnt     <= wait_cnt_next;
         delay_ms     <= delay_next;
         ReactionTime <= rt_next;
         Cheat        <= cheat_next;
         Slow         <= slow_next;
         LED          <= led_next;
         Wait         <= (state_next == S_WAIT);
         LCDUpdate    <= (state_next == S_DONE);
      end
   end

endmodule

// File: tb/tb_reaction_timer_top.sv
// Bench for reaction_timer_top: phase/elapsed-cycle model checked every cycle,
// plus directed rounds (slow, cheat, 37 ms, reset mid-round, held DONE).
module tb_reaction_timer_top;

   localparam int N    = 4;
   localparam int SLOW = 1000;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Start = 1'b0;
   logic        LCDAck = 1'b0;
   logic [7:0]  LED;
   logic [9:0]  ReactionTime;
   logic        Cheat, Slow, Wait, LCDUpdate, ClkOut;
   logic [12:0] RandomGen;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   reaction_timer_top #(.CLK_PER_MS(N), .SLOW_MS(SLOW)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .LCDAck(LCDAck),
      .LED(LED), .ReactionTime(ReactionTime), .Cheat(Cheat), .Slow(Slow),
      .Wait(Wait), .LCDUpdate(LCDUpdate), .RandomGen(RandomGen), .ClkOut(ClkOut)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {P_IDLE, P_WAIT, P_TIME, P_DONE} phase_t;
   phase_t      m_phase;
   int          m_sync, m_k, m_e, m_delay, m_rt;
   logic [12:0] m_lfsr;
   logic        m_sq, m_cheat, m_slow;

   always @(posedge Clk or negedge Rst) begin : model
      logic se;
      int   e1;
      if (!Rst) begin
         m_phase <= P_IDLE; m_sync <= 0; m_k <= 0; m_e <= 0; m_delay <= 0;
         m_rt <= 0; m_lfsr <= 13'h0001; m_sq <= 1'b0; m_cheat <= 1'b0; m_slow <= 1'b0;
      end else if (m_sync < 2) begin
         m_sync <= m_sync + 1;
      end else begin
         se = Start & ~m_sq;
         e1 = m_e + 1;
         m_sq   <= Start;
         m_k    <= m_k + 1;
         m_lfsr <= {m_lfsr[11:0], m_lfsr[12] ^ m_lfsr[3] ^ m_lfsr[2] ^ m_lfsr[0]};
         m_e    <= e1;
         case (m_phase)
            P_IDLE: if (se) begin
               m_rt <= 0; m_cheat <= 1'b0; m_slow <= 1'b0;
               m_delay <= 1000 + int'(m_lfsr[10:0]);
               m_phase <= P_WAIT; m_e <= 0;
            end
            P_WAIT: if (se) begin
               m_cheat <= 1'b1; m_rt <= 0; m_phase <= P_DONE;
            end else if (e1 == m_delay * N) begin
               m_phase <= P_TIME; m_e <= 0;
            end
            P_TIME: if (e1 % N == 0 && e1 / N == SLOW) begin
               m_rt <= SLOW; m_slow <= 1'b1; m_phase <= P_DONE;
            end else if (se) begin
               m_phase <= P_DONE;
            end else begin
               m_rt <= e1 / N;
            end
            P_DONE: if (LCDAck) m_phase <= P_IDLE;
            default: m_phase <= P_IDLE;
         endcase
      end
   end

   always @(negedge Clk) begin
      if (cmp_en) begin
         check("cyc_led",   LED, (m_phase == P_IDLE) ? 8'h01 : (m_phase == P_TIME) ? 8'hFF : 8'h00);
         check("cyc_rt",    ReactionTime, m_rt);
         check("cyc_cheat", Cheat, m_cheat);
         check("cyc_slow",  Slow, m_slow);
         check("cyc_wait",  Wait, m_phase == P_WAIT);
         check("cyc_upd",   LCDUpdate, m_phase == P_DONE);
         check("cyc_lfsr",  RandomGen, m_lfsr);
         check("cyc_clko",  ClkOut, (m_k / (N / 2)) % 2);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic pulse_start();
      Start = 1'b1; step(1); Start = 1'b0;
   endtask

   task automatic wait_led_ff();
      int n = 0;
      while (LED !== 8'hFF && n < 3050 * N) begin step(1); n++; end
      check("led_ff_reached", LED, 8'hFF);
   endtask

   task automatic wait_upd(input int budget);
      int n = 0;
      while (LCDUpdate !== 1'b1 && n < budget) begin step(1); n++; end
      check("upd_reached", LCDUpdate, 1'b1);
   endtask

   initial begin
      #2 Rst = 1'b0;
      #1 cmp_en = 1'b1;
      step(10);
      check("rst_led", LED, 8'h01);
      check("rst_lfsr", RandomGen, 13'h0001);
      check("rst_flags", {Cheat, Slow, Wait, LCDUpdate, ClkOut}, 5'b0);
      check("rst_rt", ReactionTime, 10'd0);
      Rst = 1'b1;
      step(2);
      check("sync_lfsr0", RandomGen, 13'h0001);
      step(1);
      check("lfsr1", RandomGen, 13'h0003);
      check("clko1", ClkOut, 1'b0);
      step(1);
      check("lfsr2", RandomGen, 13'h0007);
      check("clko2", ClkOut, 1'b1);
      step(1);
      check("lfsr3", RandomGen, 13'h000E);
      check("clko3", ClkOut, 1'b1);
      step(1);
      check("clko4", ClkOut, 1'b0);
      check("idle_led", LED, 8'h01);

      // Held Start: one round that ends on timeout.
      Start = 1'b1; step(1);
      check("slow_wait", Wait, 1'b1);
      check("slow_led0", LED, 8'h00);
      wait_led_ff();
      wait_upd(SLOW * N + 10);
      check("slow_flag", Slow, 1'b1);
      check("slow_rt", ReactionTime, 10'd1000);
      check("slow_led_done", LED, 8'h00);
      LCDAck = 1'b1; step(1); LCDAck = 1'b0;
      check("slow_ack_upd", LCDUpdate, 1'b0);
      check("slow_ack_led", LED, 8'h01);
      check("slow_hold_rt", ReactionTime, 10'd1000);
      Start = 1'b0; step(2);
      check("slow_no_retrigger", LED, 8'h01);

      // Press during the random delay.
      pulse_start(); step(10);
      pulse_start();
      check("cheat_flag", Cheat, 1'b1);
      check("cheat_rt", ReactionTime, 10'd0);
      check("cheat_upd", LCDUpdate, 1'b1);
      check("cheat_led", LED, 8'h00);
      for (int i = 0; i < 50; i++) begin pulse_start(); step(1); end
      check("done_hold_upd", LCDUpdate, 1'b1);
      check("done_hold_cheat", Cheat, 1'b1);
      check("done_hold_led", LED, 8'h00);
      LCDAck = 1'b1; step(1); LCDAck = 1'b0;
      check("cheat_ack_led", LED, 8'h01);
      check("cheat_keep", Cheat, 1'b1);
      step(3);

      // Press after 37 ms of lit lamps (press lands between ticks).
      pulse_start();
      wait_led_ff();
      step(149);
      pulse_start();
      check("r37_rt", ReactionTime, 10'd37);
      check("r37_flags", {Cheat, Slow}, 2'b00);
      check("r37_upd", LCDUpdate, 1'b1);
      step(5);
      check("r37_upd_held", LCDUpdate, 1'b1);
      LCDAck = 1'b1; step(1); LCDAck = 1'b0;
      check("r37_idle_led", LED, 8'h01);
      check("r37_idle_rt", ReactionTime, 10'd37);
      check("r37_idle_upd", LCDUpdate, 1'b0);
      step(3);

      // Reset while timing.
      pulse_start();
      wait_led_ff();
      step(20);
      Rst = 1'b0; #1;
      check("mid_rst_led", LED, 8'h01);
      check("mid_rst_rt", ReactionTime, 10'd0);
      check("mid_rst_flags", {Cheat, Slow, Wait, LCDUpdate, ClkOut}, 5'b0);
      check("mid_rst_lfsr", RandomGen, 13'h0001);
      step(3);
      Rst = 1'b1;
      step(10);
      check("post_rst_upd", LCDUpdate, 1'b0);
      check("post_rst_led", LED, 8'h01);

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
